sw_tdm_arbiter: RTL and testbench

- Time-division arbiter sharing one 169-bit switch output lane (swNout) between up to four HLS stream producers inside a board wrapper.
- Ownership comes from a 16-entry slot table taken from slotreg, so the lane follows the board's STDM slot schedule.
- Sequences run/drain from ap_start, registers the output flit, and emits startt/stopt timing markers for the measurement logic.

---
 rtl/fic_sw_pkg.sv | 25 ++
 rtl/slot_timer.sv | 41 ++++
 rtl/sw_tdm_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sw_tdm_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fic_sw_pkg.sv
// Shared types and slot-table field layout for the switch-lane TDM arbiter.
// Entry helpers keep the bit positions in one place.
package fic_sw_pkg;

    localparam int FLIT_W  = 169;
    localparam int ENTRY_W = 4;
    localparam int EN_BIT  = 3;
    localparam int OWN_LSB = 0;
    localparam int OWN_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    function automatic logic entry_en(input logic [ENTRY_W-1:0] entry);
        return entry[EN_BIT];
    endfunction

    function automatic logic [OWN_W-1:0] entry_owner(input logic [ENTRY_W-1:0] entry);
        return entry[OWN_LSB +: OWN_W];
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Cycle-within-slot and slot-index counters for the TDM schedule.
// The guard flag marks the last cycle of every slot.
module slot_timer #(
    parameter int SLOT_CYC = 16,
    parameter int NSLOT    = 16,
    parameter int CW       = $clog2(SLOT_CYC),
    parameter int SW       = $clog2(NSLOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [SW-1:0] slot_cnt,
    output logic          guard
);

    logic [CW-1:0] cyc_cnt_r;
    logic [SW-1:0] slot_cnt_r;

    // Slot counters: clear wins, then advance only while enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cyc_cnt_r  <= '0;
            slot_cnt_r <= '0;
        end else if (en) begin
            if (cyc_cnt_r == CW'(SLOT_CYC - 1)) begin
                cyc_cnt_r  <= '0;
                slot_cnt_r <= (slot_cnt_r == SW'(NSLOT - 1)) ? '0 : slot_cnt_r + 1'b1;
            end else begin
                cyc_cnt_r  <= cyc_cnt_r + 1'b1;
            end
        end else begin
            cyc_cnt_r  <= cyc_cnt_r;
            slot_cnt_r <= slot_cnt_r;
        end
    end

    assign slot_cnt = slot_cnt_r;
    assign guard    = (cyc_cnt_r == CW'(SLOT_CYC - 1));

endmodule

// File: rtl/sw_tdm_arbiter.sv
// Time-division arbiter multiplexing up to four stream producers onto one
// registered switch lane, following a 16-entry slot table latched at run start.
module sw_tdm_arbiter
    import fic_sw_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = FLIT_W,
    parameter int NSLOT    = 16,
    parameter int SLOT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    input  logic [NSLOT*ENTRY_W-1:0]   slotreg,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DW-1:0]         req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [3:0]                 cur_slot,
    output logic                       busy,
    output logic                       done,
    output logic                       startt_valid,
    output logic                       stopt_valid
);

    localparam int SW = $clog2(NSLOT);

    arb_state_e          state_r;
    arb_state_e          state_next_s;
    logic [ENTRY_W-1:0]  tbl_r [NSLOT];
    logic [SW-1:0]       slot_cnt_s;
    logic                guard_s;
    logic [ENTRY_W-1:0]  entry_s;
    logic [OWN_W-1:0]    owner_s;
    logic                en_s;
    logic                acc_s;
    logic                sel_valid_s;
    logic [DW-1:0]       sel_data_s;
    logic [NREQ-1:0]     req_ready_s;
    logic                xfer_s;
    logic                drain_exit_s;
    logic                out_valid_r;
    logic [DW-1:0]       out_data_r;
    logic                armed_r;
    logic                startt_r;

    slot_timer #(
        .SLOT_CYC (SLOT_CYC),
        .NSLOT    (NSLOT)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (ap_rst),
        .clr      (state_r == IDLE),
        .en       (state_r == RUN),
        .slot_cnt (slot_cnt_s),
        .guard    (guard_s)
    );

    assign entry_s = tbl_r[slot_cnt_s];
    assign owner_s = entry_owner(entry_s);
    assign en_s    = entry_en(entry_s) && (int'(owner_s) < NREQ);
    // Reset suppresses the handshake so nothing is consumed in a reset cycle.
    assign acc_s   = !ap_rst && (state_r == RUN) && en_s && !guard_s
                     && (!out_valid_r || out_ready);

    // Owner select: ready only to the slot owner, and pick its valid/data.
    always_comb begin
        req_ready_s = '0;
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_s == OWN_W'(i)) begin
                req_ready_s[i] = acc_s;
                sel_valid_s    = req_valid[i];
                sel_data_s     = req_data[i*DW +: DW];
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s       = acc_s && sel_valid_s;
    assign drain_exit_s = (state_r == DRAIN) && (!out_valid_r || out_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; ap_start is ignored while draining.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ap_start) state_next_s = RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (!ap_start) state_next_s = DRAIN;
                else           state_next_s = RUN;
            end
            DRAIN: begin
                if (drain_exit_s) state_next_s = IDLE;
                else              state_next_s = DRAIN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Slot table snapshot taken only when a run starts.
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            for (int s = 0; s < NSLOT; s++) tbl_r[s] <= '0;
        end else if ((state_r == IDLE) && ap_start) begin
            for (int s = 0; s < NSLOT; s++) tbl_r[s] <= slotreg[s*ENTRY_W +: ENTRY_W];
        end else begin
            for (int s = 0; s < NSLOT; s++) tbl_r[s] <= tbl_r[s];
        end
    end

    // One-entry output register; a stalled flit is held untouched.
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    // Start marker: armed at run entry, fires after the first transfer.
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            armed_r  <= 1'b0;
            startt_r <= 1'b0;
        end else begin
            startt_r <= xfer_s && armed_r;
            if ((state_r == IDLE) && ap_start) begin
                armed_r <= 1'b1;
            end else if (xfer_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign req_ready    = req_ready_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign cur_slot     = 4'(slot_cnt_s);
    assign busy         = (state_r != IDLE);
    assign done         = drain_exit_s;
    assign stopt_valid  = drain_exit_s;
    assign startt_valid = startt_r;

endmodule

// File: tb/tb_sw_tdm_arbiter.sv
// Directed-plus-random bench for sw_tdm_arbiter against a run-time/slot-table
// reference model; NREQ=3 so owner index 3 is out of range.
module tb_sw_tdm_arbiter;

    localparam int NREQ     = 3;
    localparam int DW       = 169;
    localparam int NSLOT    = 16;
    localparam int SLOT_CYC = 16;

    logic                  clk = 1'b0;
    logic                  ap_rst;
    logic                  ap_start;
    logic [NSLOT*4-1:0]    slotreg;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [3:0]            cur_slot;
    logic                  busy, done, startt_valid, stopt_valid;

    always #5 clk = ~clk;

    sw_tdm_arbiter #(.NREQ(NREQ), .DW(DW), .NSLOT(NSLOT), .SLOT_CYC(SLOT_CYC)) dut (
        .clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .slotreg(slotreg),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_slot(cur_slot), .busy(busy), .done(done),
        .startt_valid(startt_valid), .stopt_valid(stopt_valid)
    );

    // Reference model: 0 idle, 1 run, 2 drain; m_t = cycles spent in RUN.
    int              m_state;
    int              m_t;
    logic [3:0]      m_tbl [NSLOT];
    logic            m_ov;
    logic [DW-1:0]   m_od;
    logic            m_armed;
    logic            m_st;
    int              checks = 0;
    int              errors = 0;
    int              dut_acc = 0;
    int              startt_seen = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_data();
        logic [511:0] tmp;
        for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = $urandom;
        req_data = tmp[NREQ*DW-1:0];
    endtask

    task automatic model_reset();
        m_state = 0; m_t = 0; m_ov = 1'b0; m_od = '0; m_armed = 1'b0; m_st = 1'b0;
        for (int i = 0; i < NSLOT; i++) m_tbl[i] = 4'h0;
    endtask

    // One clock: check at negedge against the model, then advance the model.
    task automatic step();
        int slot, cyc, own;
        logic [3:0] ent;
        logic en, acc, xfer, dexit;
        logic [NREQ-1:0] er;
        logic [DW-1:0] din;
        @(negedge clk);
        slot = (m_t / SLOT_CYC) % NSLOT;
        cyc  = m_t % SLOT_CYC;
        ent  = m_tbl[slot];
        own  = int'(ent[1:0]);
        en   = ent[3] && (own < NREQ);
        acc  = !ap_rst && (m_state == 1) && en && (cyc != SLOT_CYC - 1) && (!m_ov || out_ready);
        er   = '0;
        din  = '0;
        if (acc) begin
            er[own] = 1'b1;
            din = req_data[own*DW +: DW];
        end
        xfer  = acc && ((req_valid & er) != '0);
        dexit = (m_state == 2) && (!m_ov || out_ready);
        chk("req_ready", DW'(req_ready), DW'(er));
        chk("out_valid", DW'(out_valid), DW'(m_ov));
        chk("out_data", out_data, m_od);
        chk("cur_slot", DW'(cur_slot), DW'(slot));
        chk("busy", DW'(busy), DW'(m_state != 0));
        chk("done", DW'(done), DW'(dexit));
        chk("stopt_valid", DW'(stopt_valid), DW'(dexit));
        chk("startt_valid", DW'(startt_valid), DW'(m_st));
        if ((req_ready & req_valid) != '0) dut_acc++;
        if (startt_valid) startt_seen++;
        @(posedge clk);
        if (ap_rst) begin
            model_reset();
        end else begin
            m_st = xfer && m_armed;
            if (xfer) m_armed = 1'b0;
            if (xfer) begin
                m_ov = 1'b1;
                m_od = din;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            case (m_state)
                0: begin
                    m_t = 0;
                    if (ap_start) begin
                        m_state = 1;
                        m_armed = 1'b1;
                        for (int i = 0; i < NSLOT; i++) m_tbl[i] = slotreg[i*4 +: 4];
                    end
                end
                1: begin
                    m_t = m_t + 1;
                    if (!ap_start) m_state = 2;
                end
                default: if (dexit) m_state = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0; slotreg = '0; req_valid = '0;
        req_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        ap_rst = 1'b0;
        step();

        // Single owner streaming: all slots req0, 15 accepts in the first slot.
        slotreg = 64'h8888_8888_8888_8888;
        req_valid = 3'b001;
        ap_start = 1'b1;
        rnd_data();
        step();
        dut_acc = 0;
        startt_seen = 0;
        for (int c = 0; c < SLOT_CYC; c++) begin
            rnd_data();
            step();
        end
        chk("slot0_flits", DW'(dut_acc), DW'(15));
        for (int c = 0; c < 24; c++) begin
            rnd_data();
            step();
        end
        chk("startt_once", DW'(startt_seen), DW'(1));
        ap_start = 1'b0;
        repeat (4) step();

        // Round robin with owner 3 out of range in every fourth slot.
        slotreg = 64'hBA98_BA98_BA98_BA98;
        req_valid = 3'b111;
        ap_start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            rnd_data();
            step();
        end
        ap_start = 1'b0;
        repeat (4) step();

        // Disabled slot 0, out-of-range slot 1, then live slots.
        slotreg = 64'h0000_0000_0000_89B0;
        ap_start = 1'b1;
        step();
        dut_acc = 0;
        for (int c = 0; c < 2 * SLOT_CYC; c++) begin
            req_valid = 3'($urandom_range(1, 7));
            rnd_data();
            step();
        end
        chk("idle_slots_no_accept", DW'(dut_acc), DW'(0));
        for (int c = 0; c < 20; c++) begin
            rnd_data();
            step();
        end
        ap_start = 1'b0;
        repeat (4) step();

        // Backpressure across the slot 0/1 boundary.
        slotreg = 64'h9898_9898_9898_9898;
        req_valid = 3'b011;
        ap_start = 1'b1;
        step();
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 10 && c < SLOT_CYC + 3);
            rnd_data();
            step();
        end
        out_ready = 1'b1;

        // Drain with a stalled flit; ap_start pulses during drain are ignored.
        out_ready = 1'b0;
        step();
        ap_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ap_start = (c == 2);
            step();
        end
        ap_start = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset mid-run while a flit is held, then a fresh run relatches.
        slotreg = 64'h8888_8888_8888_8888;
        req_valid = 3'b001;
        ap_start = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        ap_start = 1'b0;
        out_ready = 1'b1;
        step();
        slotreg = 64'h9999_9999_9999_9999;
        req_valid = 3'b011;
        ap_start = 1'b1;
        repeat (10) step();

        // Random soak.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 29) == 0) ap_start = ~ap_start;
            ap_rst    = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            req_valid = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) slotreg = {$urandom, $urandom};
            rnd_data();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
